fc_argmax_layer: RTL



---
 rtl/fc_pkg.sv | 37 +++
 rtl/fc_mac_lanes.sv | 24 ++
 rtl/fc_argmax_layer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/fc_pkg.sv
// Shared types and helpers for the fully-connected argmax layer:
// the controller state encoding plus sign-extend and saturate functions.
package fc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        MAC,
        BIAS,
        DONE
    } state_t;

    // Sign-extend the low w bits of x to 64 bits.
    function automatic logic signed [63:0] sext(
        input logic [63:0] x,
        input int          w
    );
        logic signed [63:0] t;
        t = signed'(x << (64 - w));
        return t >>> (64 - w);
    endfunction

    // Clamp x to the signed range of a w-bit value.
    function automatic logic signed [63:0] sat(
        input logic signed [63:0] x,
        input int                 w
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

endpackage

// File: rtl/fc_mac_lanes.sv
// Combinational LANES-wide signed multiply and sum.
// Ports: a (inputs), w (weights), sum (ACC_W signed, wraps).
module fc_mac_lanes #(
    parameter int LANES = 32,
    parameter int DIN_W = 18,
    parameter int WGT_W = 9,
    parameter int ACC_W = 36
) (
    input  logic signed [DIN_W-1:0] a   [LANES],
    input  logic signed [WGT_W-1:0] w   [LANES],
    output logic signed [ACC_W-1:0] sum
);

    logic signed [DIN_W+WGT_W-1:0] prod [LANES];

    always_comb begin
        sum = '0;
        for (int l = 0; l < LANES; l++) begin
            prod[l] = a[l] * w[l];
            sum     = sum + ACC_W'(prod[l]);
        end
    end

endmodule

// File: rtl/fc_argmax_layer.sv
// Fully-connected layer with argmax: streams weight rows from a
// synchronous ROM, adds bias, rescales, saturates and keeps the max.
// Ports: clk, rst_n, strt/din (request), w_addr/w_data and
// b_addr/b_data (ROM), busy, result_valid/class_idx/class_score/tx_done.
module fc_argmax_layer
    import fc_pkg::*;
#(
    parameter int N_IN     = 64,
    parameter int N_OUT    = 10,
    parameter int LANES    = 32,
    parameter int DIN_W    = 18,
    parameter int WGT_W    = 9,
    parameter int ACC_W    = 36,
    parameter int BIAS_SHL = 8,
    parameter int OUT_SHR  = 8,
    parameter int RELU_EN  = 1,
    localparam int CHUNKS  = N_IN / LANES,
    localparam int AW      = (N_OUT * CHUNKS > 1) ? $clog2(N_OUT * CHUNKS) : 1,
    localparam int NW      = $clog2(N_OUT),
    localparam int CW      = (CHUNKS > 1) ? $clog2(CHUNKS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    strt,
    input  logic signed [DIN_W-1:0] din [N_IN],
    output logic [AW-1:0]           w_addr,
    input  logic signed [WGT_W-1:0] w_data [LANES],
    output logic [NW-1:0]           b_addr,
    input  logic [WGT_W-1:0]        b_data,
    output logic                    busy,
    output logic                    result_valid,
    output logic [7:0]              class_idx,
    output logic signed [DIN_W-1:0] class_score,
    input  logic                    tx_done
);

    state_t state;
    state_t state_nxt;

    logic signed [DIN_W-1:0] din_q    [N_IN];
    logic signed [DIN_W-1:0] lane_din [LANES];
    logic [CW-1:0]           c;
    logic [NW-1:0]           n;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] mac_sum;
    logic signed [ACC_W-1:0] biased;
    logic signed [ACC_W-1:0] shifted;
    logic signed [DIN_W-1:0] score_raw;
    logic signed [DIN_W-1:0] score;
    logic [7:0]              best_idx;
    logic signed [DIN_W-1:0] best_score;

    wire last_c = (c == CW'(CHUNKS - 1));
    wire last_n = (n == NW'(N_OUT - 1));

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_din[l] = din_q[int'(c) * LANES + l];
        end
    end

    fc_mac_lanes #(
        .LANES(LANES),
        .DIN_W(DIN_W),
        .WGT_W(WGT_W),
        .ACC_W(ACC_W)
    ) u_mac (
        .a  (lane_din),
        .w  (w_data),
        .sum(mac_sum)
    );

    always_comb begin
        biased    = acc + ACC_W'(sext(64'(b_data), WGT_W) <<< BIAS_SHL);
        shifted   = biased >>> OUT_SHR;
        score_raw = DIN_W'(sat(64'(shifted), DIN_W));
        score     = score_raw;
        if (RELU_EN != 0 && score_raw[DIN_W-1]) begin
            score = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (strt) state_nxt = PRIME;
            PRIME: state_nxt = MAC;
            MAC:   if (last_c) state_nxt = BIAS;
            BIAS:  state_nxt = last_n ? DONE : MAC;
            DONE:  if (result_valid && tx_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The ROM row for the next MAC cycle is addressed one cycle early;
    // c stays at its last value in BIAS so the next neuron's row 0 is held.
    always_comb begin
        busy   = 1'b0;
        w_addr = '0;
        b_addr = n;
        unique case (state)
            PRIME: busy = 1'b1;
            MAC, BIAS: begin
                busy   = 1'b1;
                w_addr = AW'(int'(n) * CHUNKS + int'(c) + 1);
            end
            DONE:    busy = !result_valid;
            default: ;
        endcase
    end

    // The winner is copied to the output registers one cycle after the
    // last bias step, so the previous result stays visible during a run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_q        <= '{default: '0};
            c            <= '0;
            n            <= '0;
            acc          <= '0;
            best_idx     <= '0;
            best_score   <= '0;
            result_valid <= 1'b0;
            class_idx    <= '0;
            class_score  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (strt) begin
                        din_q <= din;
                        c     <= '0;
                        n     <= '0;
                    end
                end
                MAC: begin
                    acc <= ((c == '0) ? '0 : acc) + mac_sum;
                    if (!last_c) c <= c + 1'b1;
                end
                BIAS: begin
                    c <= '0;
                    if (n == '0 || score > best_score) begin
                        best_score <= score;
                        best_idx   <= 8'(n);
                    end
                    n <= last_n ? '0 : n + 1'b1;
                end
                DONE: begin
                    if (!result_valid) begin
                        result_valid <= 1'b1;
                        class_idx    <= best_idx;
                        class_score  <= best_score;
                    end else if (tx_done) begin
                        result_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
